// File: rtl/lstm_acc_pkg.sv
// Shared types and saturating arithmetic for the LSTM row accumulator stage.
package lstm_acc_pkg;

   localparam int unsigned ELEM_W = 8;
   localparam int unsigned ROW_W  = 4;

   typedef logic [ELEM_W-1:0] elem_t;

   typedef enum logic {FIRST, ACCUM} acc_state_t;

   typedef struct packed {
      elem_t             data;
      logic [ROW_W-1:0]  row;
      logic              frame_last;
   } row_entry_t;

   // Bit ELEM_W of the result flags saturation; low bits are the clamped sum.
   function automatic logic [ELEM_W:0] sat_add(input elem_t a, input elem_t b);
      logic [ELEM_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[ELEM_W] ? {1'b1, {ELEM_W{1'b1}}} : sum;
   endfunction

endpackage

// File: rtl/row_result_fifo.sv
// Synchronous FIFO of tagged row results; head is read straight from the register array.
module row_result_fifo
   import lstm_acc_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic       push,
   input  row_entry_t wdata,
   input  logic       pop,
   output row_entry_t rdata,
   output logic       full,
   output logic       empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   row_entry_t      mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            do_push;
   logic            do_pop;

   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/mvm_row_accumulator.sv
// Sums CHUNKS saturated MVM partials plus a row bias into one tagged, buffered row result.
module mvm_row_accumulator
   import lstm_acc_pkg::*;
#(
   parameter int unsigned N      = ELEM_W,
   parameter int unsigned CHUNKS = 4,
   parameter int unsigned ROWS   = 16,
   parameter int unsigned DEPTH  = 2
) (
   input  logic                    CLOCK_50,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N-1:0]            in_data,
   input  logic [N-1:0]            bias,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [N-1:0]            out_data,
   output logic [$clog2(ROWS)-1:0] out_row,
   output logic                    out_frame_last,
   output logic                    sat_flag
);

   localparam int unsigned CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int unsigned RW = $clog2(ROWS);

   acc_state_t    state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [RW-1:0] row, row_next;
   elem_t         acc, acc_next;
   logic          sat_next;
   logic          final_chunk;
   logic          pop;
   logic          accept;
   logic          push;
   logic          full;
   logic          empty;
   logic [N:0]    sum;
   row_entry_t    wentry;
   row_entry_t    rentry;

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) state <= FIRST;
      else          state <= state_next;
   end

   // Next-state, handshake and datapath update; in_ready never looks at in_valid.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      row_next    = row;
      acc_next    = acc;
      sat_next    = sat_flag;
      final_chunk = (CHUNKS == 1) ? (state == FIRST)
                                  : (state == ACCUM && cnt == CW'(CHUNKS - 1));
      pop         = !empty && out_ready;
      in_ready    = final_chunk ? (!full || pop) : 1'b1;
      accept      = in_valid && in_ready;
      push        = accept && final_chunk;
      sum         = sat_add((state == FIRST) ? bias : acc, in_data);
      wentry      = '{data: sum[N-1:0], row: row, frame_last: (row == RW'(ROWS - 1))};
      if (accept) begin
         sat_next = sat_flag | sum[N];
         if (push) begin
            state_next = FIRST;
            cnt_next   = '0;
            row_next   = (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
         end else if (state == FIRST) begin
            acc_next   = sum[N-1:0];
            cnt_next   = CW'(1);
            state_next = ACCUM;
         end else begin
            acc_next   = sum[N-1:0];
            cnt_next   = cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         cnt      <= '0;
         row      <= '0;
         acc      <= '0;
         sat_flag <= 1'b0;
      end else begin
         cnt      <= cnt_next;
         row      <= row_next;
         acc      <= acc_next;
         sat_flag <= sat_next;
      end
   end

   row_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .push     (push),
      .wdata    (wentry),
      .pop      (pop),
      .rdata    (rentry),
      .full     (full),
      .empty    (empty)
   );

   assign out_valid      = !empty;
   assign out_data       = rentry.data;
   assign out_row        = rentry.row;
   assign out_frame_last = rentry.frame_last;

endmodule

// File: tb/tb_mvm_row_accumulator.sv
// Directed, table-driven bench for mvm_row_accumulator (N=8, CHUNKS=4, ROWS=16, DEPTH=2).
module tb_mvm_row_accumulator;

   logic       CLOCK_50 = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [7:0] bias;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [3:0] out_row;
   logic       out_frame_last;
   logic       sat_flag;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] bias;
      logic [7:0] p0, p1, p2, p3;
      logic [7:0] exp_data;
      logic [3:0] exp_row;
      logic       exp_sat;
   } vec_t;

   typedef struct packed {
      logic [7:0] d;
      logic [3:0] r;
      logic       fl;
   } obs_t;

   vec_t vecs [4];
   obs_t q [$];

   mvm_row_accumulator dut (
      .CLOCK_50       (CLOCK_50),
      .reset_n        (reset_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .bias           (bias),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_row        (out_row),
      .out_frame_last (out_frame_last),
      .sat_flag       (sat_flag)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Record every popped head mid-cycle, when all signals are settled.
   always @(negedge CLOCK_50) begin
      if (reset_n && out_valid && out_ready)
         q.push_back('{d: out_data, r: out_row, fl: out_frame_last});
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   // Present one partial and hold it until the DUT accepts it.
   task automatic send(input logic [7:0] b, input logic [7:0] d);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = d;
      bias     = b;
      @(negedge CLOCK_50);
      while (!in_ready && guard < 200) begin
         guard++;
         tick();
         @(negedge CLOCK_50);
      end
      if (guard >= 200) check("send_timeout", 0, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_row(input logic [7:0] b, input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3, input bit gaps);
      send(b, p0); if (gaps) tick();
      send(b, p1); if (gaps) tick();
      send(b, p2); if (gaps) tick();
      send(b, p3);
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      in_valid = 1'b0;
      tick();
      tick();
      reset_n  = 1'b1;
      q.delete();
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      bias      = '0;
      out_ready = 1'b1;

      vecs[0] = '{bias: 8'd3,   p0: 8'd10,  p1: 8'd20, p2: 8'd30, p3: 8'd40,
                  exp_data: 8'd103, exp_row: 4'd0, exp_sat: 1'b0};
      vecs[1] = '{bias: 8'd200, p0: 8'd50,  p1: 8'd10, p2: 8'd0,  p3: 8'd0,
                  exp_data: 8'd255, exp_row: 4'd1, exp_sat: 1'b1};
      vecs[2] = '{bias: 8'd1,   p0: 8'd2,   p1: 8'd3,  p2: 8'd4,  p3: 8'd5,
                  exp_data: 8'd15,  exp_row: 4'd2, exp_sat: 1'b1};
      vecs[3] = '{bias: 8'd0,   p0: 8'd255, p1: 8'd0,  p2: 8'd0,  p3: 8'd1,
                  exp_data: 8'd255, exp_row: 4'd3, exp_sat: 1'b1};

      tick(); tick(); tick();
      reset_n = 1'b1;
      @(negedge CLOCK_50);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_out_row", int'(out_row), 0);
      check("rst_frame_last", int'(out_frame_last), 0);
      check("rst_sat_flag", int'(sat_flag), 0);
      check("rst_in_ready", int'(in_ready), 1);
      tick();

      // Gapless rows; each result must be visible the cycle after its final accept.
      for (int i = 0; i < 4; i++) begin
         send_row(vecs[i].bias, vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3, 1'b0);
         @(negedge CLOCK_50);
         check($sformatf("vec%0d_valid", i), int'(out_valid), 1);
         check($sformatf("vec%0d_data", i), int'(out_data), int'(vecs[i].exp_data));
         check($sformatf("vec%0d_row", i), int'(out_row), int'(vecs[i].exp_row));
         check($sformatf("vec%0d_last", i), int'(out_frame_last), 0);
         check($sformatf("vec%0d_sat", i), int'(sat_flag), int'(vecs[i].exp_sat));
         tick();
      end

      // Backpressure: two rows fill the FIFO, third row's final chunk must stall.
      do_reset();
      out_ready = 1'b0;
      send_row(8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
      send_row(8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
      send(8'd0, 8'd1);
      send(8'd0, 8'd1);
      send(8'd0, 8'd1);
      in_valid = 1'b1;
      in_data  = 8'd1;
      bias     = 8'd0;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLOCK_50);
         check($sformatf("bp_stall%0d_in_ready", c), int'(in_ready), 0);
         check($sformatf("bp_stall%0d_data", c), int'(out_data), 4);
         check($sformatf("bp_stall%0d_row", c), int'(out_row), 0);
         tick();
      end
      out_ready = 1'b1;
      @(negedge CLOCK_50);
      check("bp_pushpop_in_ready", int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      check("bp_count", q.size(), 3);
      for (int k = 0; k < 3 && k < q.size(); k++) begin
         check($sformatf("bp_out%0d_data", k), int'(q[k].d), 4);
         check($sformatf("bp_out%0d_row", k), int'(q[k].r), k);
      end

      // Frame wrap: 16 rows with bias = row index, then one more row.
      do_reset();
      for (int r = 0; r < 16; r++) send_row(8'(r), 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
      send_row(8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
      repeat (4) tick();
      check("wrap_count", q.size(), 17);
      for (int r = 0; r < 17 && r < q.size(); r++) begin
         check($sformatf("wrap%0d_data", r), int'(q[r].d), (r < 16) ? r : 7);
         check($sformatf("wrap%0d_row", r), int'(q[r].r), (r < 16) ? r : 0);
         check($sformatf("wrap%0d_last", r), int'(q[r].fl), (r == 15) ? 1 : 0);
      end

      // Reset with a saturated entry pending and a row half accumulated.
      do_reset();
      out_ready = 1'b0;
      send_row(8'd200, 8'd100, 8'd0, 8'd0, 8'd0, 1'b0);
      send(8'd0, 8'd1);
      send(8'd0, 8'd1);
      @(negedge CLOCK_50);
      check("mid_pre_sat", int'(sat_flag), 1);
      check("mid_pre_valid", int'(out_valid), 1);
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      @(negedge CLOCK_50);
      check("mid_post_valid", int'(out_valid), 0);
      check("mid_post_sat", int'(sat_flag), 0);
      tick();
      out_ready = 1'b1;
      send_row(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
      @(negedge CLOCK_50);
      check("mid_fresh_valid", int'(out_valid), 1);
      check("mid_fresh_data", int'(out_data), 5);
      check("mid_fresh_row", int'(out_row), 0);
      tick();

      // Bubbles between partials must not change the results.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         send_row(vecs[i].bias, vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3, 1'b1);
         tick();
      end
      repeat (3) tick();
      check("bub_count", q.size(), 3);
      for (int i = 0; i < 3 && i < q.size(); i++) begin
         check($sformatf("bub%0d_data", i), int'(q[i].d), int'(vecs[i].exp_data));
         check($sformatf("bub%0d_row", i), int'(q[i].r), int'(vecs[i].exp_row));
      end
      check("bub_sat", int'(sat_flag), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
